// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//
// Packs decoded RV32I fields into 32-bit instruction words. Each word is
// buffered in a small FIFO and streamed to the instruction-memory write port
// with an auto-incrementing word address. The self-test / program-load path
// uses it to build programs in memory without an external assembler.
//
// Handshake semantics (both sides): a transfer happens on the rising edge
// where valid and ready are both 1. A producer holds valid and its payload
// stable until that edge. ready never depends on valid in the same cycle.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         one-cycle pulse: address counter <= base_addr, err <= 0
//   base_addr     first word address used after start
//   in_valid      field bundle valid
//   in_ready      FIFO not full
//   typ           opcode (I-ALU, load, store, branch, R)
//   rd, rs1, rs2  register fields
//   funct3        funct3 field
//   funct7        funct7 field (R-type only)
//   imm           two's-complement immediate
//   out_valid     word at FIFO head
//   out_ready     memory accepts the word
//   out_addr      word address of the head word (the address counter)
//   out_data      packed instruction at the head (0 when empty)
//   err           sticky: an accepted bundle was rejected by the range check
//   count         FIFO occupancy after the most recent edge
module instr_encoder_loader #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 typ,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [31:0]                imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [31:0]                out_data,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;

  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  logic [31:0]        packed_word;
  logic               range_ok;
  logic signed [31:0] imm_s;
  logic               push_req;
  logic               push;
  logic               pop;

  assign imm_s = imm;

  // Field packing and range check. Unknown opcodes leave range_ok low so the
  // bundle is consumed but never reaches the FIFO.
  always_comb begin
    packed_word = '0;
    range_ok    = 1'b0;
    unique case (typ)
      OP_IALU, OP_LOAD: begin
        packed_word = {imm[11:0], rs1, funct3, rd, typ};
        range_ok    = (imm_s >= -2048) && (imm_s <= 2047);
      end
      OP_STORE: begin
        packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], typ};
        range_ok    = (imm_s >= -2048) && (imm_s <= 2047);
      end
      OP_BRANCH: begin
        packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], typ};
        range_ok    = (imm_s >= -4096) && (imm_s <= 4094) && !imm[0];
      end
      OP_R: begin
        packed_word = {funct7, rs2, rs1, funct3, rd, typ};
        range_ok    = 1'b1;
      end
      default: begin
        packed_word = '0;
        range_ok    = 1'b0;
      end
    endcase
  end

  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push_req  = in_valid & in_ready;
  assign push      = push_req & range_ok;
  assign pop       = out_valid & out_ready;

  assign out_addr = addr_q;
  assign out_data = out_valid ? mem[rd_ptr] : 32'd0;
  assign err      = err_q;
  assign count    = cnt;

  // Storage has no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= packed_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      // start takes priority over a coincident pop; the increment is lost.
      if (start) begin
        addr_q <= base_addr;
      end else if (pop) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      // A rejection in the same cycle as start still latches the error.
      if (push_req && !range_ok) begin
        err_q <= 1'b1;
      end else if (start) begin
        err_q <= 1'b0;
      end
    end
  end

endmodule
